serial_greater_comparator: RTL and testbench
============================================

Name: serial_greater_comparator

Overview:
- Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned operands.
- Sequential counterpart of the parallel 4-bit greater-than circuit, used where operands arrive one bit per cycle (shift-register or serial-link front ends).
- Consumes one (a_bit, b_bit) pair per accepted cycle and reports gt/lt/eq after the last bit, with a start/valid/done handshake.

Parameters:
WIDTH  4  operand width in bits; legal range 2..32

Ports:
clk        input   1                      rising-edge system clock
rst_n      input   1                      asynchronous active-low reset
start      input   1                      begin new comparison; sampled only when not busy
bit_valid  input   1                      a_bit/b_bit hold a valid pair this cycle
a_bit      input   1                      current bit of operand A, MSB first
b_bit      input   1                      current bit of operand B, MSB first
busy       output  1                      comparison in progress (state COMPARE)
done       output  1                      one-cycle pulse: result valid and final
gt         output  1                      A > B (registered, held until next start)
lt         output  1                      A < B (registered, held until next start)
eq         output  1                      A == B (registered, held until next start)
bit_cnt    output  $clog2(WIDTH+1)        bits consumed in the current comparison (debug)

Behaviour:
- Reset is asynchronous and active-low; all flops clear immediately on rst_n=0:
  - state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0, bit_cnt=0.
  - Internal decided flag=0.
- FSM states:
  - IDLE:
    - start=1 -> COMPARE; clear gt/lt/decided, set eq=1, bit_cnt=0.
    - bit_valid is ignored.
  - COMPARE:
    - busy=1.
    - Each cycle with bit_valid=1, one pair is accepted and bit_cnt increments.
    - If decided=0 and a_bit!=b_bit: gt=a_bit, lt=b_bit, eq=0, decided=1.
    - Once decided=1, later bits are consumed but never change gt/lt/eq (MSB dominance).
    - When the accepted pair is bit WIDTH (bit_cnt reaches WIDTH-1 before the increment) -> DONE.
    - bit_valid=0 stalls with no state change; gaps of any length are legal.
  - DONE:
    - done=1 for exactly one cycle, busy=0, then -> IDLE.
    - start is ignored in DONE.
- Latency:
  - With back-to-back valids: start at cycle 0, bits on cycles 1..WIDTH, done high on cycle WIDTH+1.
  - In general, done asserts the cycle after the last pair is accepted.
- Invariant: exactly one of gt/lt/eq is 1 from the first cycle in COMPARE onward; all three are 0 only after reset before the first start.
- Result hold: gt/lt/eq keep their value through DONE and IDLE until the next accepted start clears them.
- start while busy is ignored; it neither restarts nor corrupts the comparison.
- start and bit_valid in the same IDLE cycle: start is taken, the bit is NOT consumed (first bit is accepted the following cycle).
- rst_n asserted mid-comparison: abort immediately to IDLE with all outputs 0; no done pulse is produced.
- bit_cnt saturates at WIDTH, is never wrapped, and clears on start.

Test Plan:
1. Reset, then start; feed A=1100, B=0001 MSB-first on consecutive cycles -> decided at bit 1; done pulses cycle 5 after start; gt=1, lt=0, eq=0.
2. A=0010, B=0100 -> decided at bit 2; at done: lt=1, gt=0, eq=0. Then A=0010, B=0000 -> gt=1 (decided at bit 3).
3. A=1000, B=1010 with bit_valid deasserted for 3 cycles between bits 2 and 3 -> busy stays 1 through the stall; done one cycle after the 4th valid; lt=1.
4. A=1111, B=1111 -> eq=1, gt=0, lt=0 at done; outputs hold for 10 idle cycles; a second start with A=0000, B=0000 -> eq=1 again.
5. Pulse start during bit 2 of an A=0101, B=0011 compare -> ignored; result at done is gt=1 after exactly 4 bits.
6. Drop rst_n low after 2 bits of A=1100, B=1000 -> outputs 0 asynchronously, no done; after release, a fresh compare of A=0001, B=0010 yields lt=1.

Source files
------------

// File: rtl/serial_greater_comparator_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The master drives operand bits and start; the slave (comparator) returns status and result.
interface serial_greater_comparator_if #(
    parameter int WIDTH = 4
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, gt, lt, eq, bit_cnt
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, gt, lt, eq, bit_cnt
    );
endinterface

// File: rtl/serial_greater_comparator.sv
// Bit-serial MSB-first comparator: the first differing bit pair decides gt/lt,
// later bits are consumed without effect, and done pulses after the last bit.
module serial_greater_comparator #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_greater_comparator_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    logic             decided;
    logic             busy_r;
    logic             done_r;
    logic             gt_r;
    logic             lt_r;
    logic             eq_r;
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            decided <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            eq_r    <= 1'b0;
            cnt_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // A bit presented alongside start is deliberately not consumed.
                    if (bus.start) begin
                        state   <= COMPARE;
                        busy_r  <= 1'b1;
                        gt_r    <= 1'b0;
                        lt_r    <= 1'b0;
                        eq_r    <= 1'b1;
                        decided <= 1'b0;
                        cnt_r   <= '0;
                    end
                end
                COMPARE: begin
                    if (bus.bit_valid) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (!decided && (bus.a_bit != bus.b_bit)) begin
                            gt_r    <= bus.a_bit;
                            lt_r    <= bus.b_bit;
                            eq_r    <= 1'b0;
                            decided <= 1'b1;
                        end
                        if (cnt_r == CNT_W'(WIDTH - 1)) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.gt      = gt_r;
    assign bus.lt      = lt_r;
    assign bus.eq      = eq_r;
    assign bus.bit_cnt = cnt_r;
endmodule

// File: tb/tb_serial_greater_comparator.sv
// Directed and randomized bench for serial_greater_comparator; results are
// predicted by integer comparison of the whole operands.
module tb_serial_greater_comparator;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    serial_greater_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_greater_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        check_output({tag, ".gt"}, 32'(bus.gt), 32'(a > b));
        check_output({tag, ".lt"}, 32'(bus.lt), 32'(a < b));
        check_output({tag, ".eq"}, 32'(bus.eq), 32'(a == b));
    endtask

    // Runs one full comparison; inputs change on the falling edge, outputs are checked there too.
    task automatic apply_stimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input int stall_after, input int stall_len,
                                  input int glitch_at, input bit valid_with_start);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bit_valid = valid_with_start;
        bus.a_bit     = 1'($urandom);
        bus.b_bit     = 1'($urandom);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        check_output({tag, ".busy_start"}, 32'(bus.busy), 32'd1);
        check_output({tag, ".cnt_start"}, 32'(bus.bit_cnt), 32'd0);
        check_result({tag, ".cleared"}, 0, 0);
        for (int i = 0; i < WIDTH; i++) begin
            bus.bit_valid = 1'b1;
            bus.a_bit     = a[WIDTH-1-i];
            bus.b_bit     = b[WIDTH-1-i];
            bus.start     = (i == glitch_at);
            @(negedge clk);
            bus.bit_valid = 1'b0;
            bus.start     = 1'b0;
            if (i < WIDTH - 1) begin
                check_output({tag, ".busy_bit"}, 32'(bus.busy), 32'd1);
                check_output({tag, ".done_early"}, 32'(bus.done), 32'd0);
                check_output({tag, ".cnt_bit"}, 32'(bus.bit_cnt), 32'(i + 1));
                check_output({tag, ".onehot"}, 32'(bus.gt) + 32'(bus.lt) + 32'(bus.eq), 32'd1);
            end
            if (i == stall_after && i < WIDTH - 1) begin
                repeat (stall_len) begin
                    bus.a_bit = 1'($urandom);
                    bus.b_bit = 1'($urandom);
                    @(negedge clk);
                    check_output({tag, ".busy_stall"}, 32'(bus.busy), 32'd1);
                    check_output({tag, ".cnt_stall"}, 32'(bus.bit_cnt), 32'(i + 1));
                    check_output({tag, ".done_stall"}, 32'(bus.done), 32'd0);
                end
            end
        end
        check_output({tag, ".done"}, 32'(bus.done), 32'd1);
        check_output({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
        check_output({tag, ".cnt_done"}, 32'(bus.bit_cnt), 32'(WIDTH));
        check_result({tag, ".result"}, int'(a), int'(b));
        @(negedge clk);
        check_output({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check_result({tag, ".held"}, int'(a), int'(b));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'b0;
        bus.b_bit     = 1'b0;

        #2;
        check_output("reset.busy", 32'(bus.busy), 32'd0);
        check_output("reset.done", 32'(bus.done), 32'd0);
        check_output("reset.cnt", 32'(bus.bit_cnt), 32'd0);
        check_output("reset.gt", 32'(bus.gt), 32'd0);
        check_output("reset.lt", 32'(bus.lt), 32'd0);
        check_output("reset.eq", 32'(bus.eq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed compares");
        apply_stimulus("t1", 4'b1100, 4'b0001, -1, 0, -1, 1'b0);
        apply_stimulus("t2a", 4'b0010, 4'b0100, -1, 0, -1, 1'b0);
        apply_stimulus("t2b", 4'b0010, 4'b0000, -1, 0, -1, 1'b0);
        apply_stimulus("t3", 4'b1000, 4'b1010, 1, 3, -1, 1'b0);
        apply_stimulus("t4a", 4'b1111, 4'b1111, -1, 0, -1, 1'b0);

        // Idle bits must not disturb the held result.
        repeat (10) begin
            bus.bit_valid = 1'b1;
            bus.a_bit     = 1'b1;
            bus.b_bit     = 1'b0;
            @(negedge clk);
            check_result("t4.hold", 1, 1);
            check_output("t4.hold_cnt", 32'(bus.bit_cnt), 32'(WIDTH));
        end
        bus.bit_valid = 1'b0;
        apply_stimulus("t4b", 4'b0000, 4'b0000, -1, 0, -1, 1'b1);
        apply_stimulus("t5", 4'b0101, 4'b0011, -1, 0, 1, 1'b0);

        $display("[TB] mid-compare reset");
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bit_valid = 1'b1;
            bus.a_bit     = ra_bit(4'b1100, i);
            bus.b_bit     = ra_bit(4'b1000, i);
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("t6.busy", 32'(bus.busy), 32'd0);
        check_output("t6.cnt", 32'(bus.bit_cnt), 32'd0);
        check_output("t6.gt", 32'(bus.gt), 32'd0);
        check_output("t6.lt", 32'(bus.lt), 32'd0);
        check_output("t6.eq", 32'(bus.eq), 32'd0);
        repeat (3) begin
            bus.bit_valid = 1'b1;
            @(negedge clk);
            check_output("t6.no_done", 32'(bus.done), 32'd0);
        end
        bus.bit_valid = 1'b0;
        rst_n = 1'b1;
        apply_stimulus("t6b", 4'b0001, 4'b0010, -1, 0, -1, 1'b0);

        $display("[TB] randomized compares");
        for (int n = 0; n < 24; n++) begin
            ra = WIDTH'($urandom);
            rb = (n % 4 == 0) ? ra : WIDTH'($urandom);
            apply_stimulus("rand", ra, rb, int'($urandom_range(WIDTH - 1, 0)) - 1,
                           int'($urandom_range(4, 0)), int'($urandom_range(WIDTH, 0)) - 1,
                           1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic ra_bit(input logic [WIDTH-1:0] v, input int i);
        return v[WIDTH-1-i];
    endfunction
endmodule
